// File: rtl/adder_pkg.sv
// adder_pkg: shared types and widths for the 24-bit prefix adder and the
// limb carry chain wrapped around it.
package adder_pkg;

  localparam int unsigned LIMB_W    = 24;
  localparam int unsigned MAX_LIMBS = 16;
  localparam int unsigned LIMB_IDX_W = $clog2(MAX_LIMBS);

  typedef enum logic {
    FIRST = 1'b0,
    RUN   = 1'b1
  } chain_state_t;

  // Registered result limb presented on the output stream.
  typedef struct packed {
    logic [LIMB_W-1:0]     sum;
    logic [LIMB_IDX_W-1:0] idx;
    logic                  last;
    logic                  cout;
    logic                  err;
  } limb_res_t;

endpackage

// File: rtl/adder.sv
// adder: combinational 24-bit Kogge-Stone prefix adder.
// Ports:
//   a, b  in  W   operands
//   cin   in  1   carry-in
//   sum   out W   a + b + cin (low W bits)
//   cout  out 1   carry-out of the MSB
module adder
  import adder_pkg::*;
#(
  parameter int unsigned W = LIMB_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned LEVELS = $clog2(W);

  // Returns {cout, sum}; cin is folded into the bit-0 generate term.
  function automatic logic [W:0] prefix_add(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic         ci);
    logic [W-1:0] t;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W-1:0] s;
    t    = x ^ y;
    g    = x & y;
    g[0] = g[0] | (t[0] & ci);
    p    = t;
    for (int l = 0; l < int'(LEVELS); l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < int'(W); i++) begin
        if (i >= (1 << l)) begin
          gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
          pn[i] = p[i] & p[i-(1<<l)];
        end
      end
      g = gn;
      p = pn;
    end
    s[0] = t[0] ^ ci;
    for (int i = 1; i < int'(W); i++) begin
      s[i] = t[i] ^ g[i-1];
    end
    return {g[W-1], s};
  endfunction

  logic [W:0] w_res;

  assign w_res = prefix_add(a, b, cin);
  assign sum   = w_res[W-1:0];
  assign cout  = w_res[W];

endmodule

// File: rtl/limb_carry_chain.sv
// limb_carry_chain: streams multi-limb additions through one 24-bit adder,
// LS limb first, carrying between limbs in a register. One-stage registered
// output; in_ready is combinational (no skid buffer).
// Optional feature macro: LIMB_CARRY_SIGNED_OVF_EN adds out_ovf, the
// two's-complement overflow of the whole packet, reported on the last limb.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready                input limb handshake
//   in_a, in_b, in_cin, in_last      operand limbs, packet cin, last marker
//   out_valid/out_ready              output limb handshake
//   out_sum, out_idx, out_last       sum limb, limb index, last marker
//   out_cout, out_err                packet carry-out, length error
//   out_ovf (macro only)             signed overflow on last limb
module limb_carry_chain
  import adder_pkg::*;
#(
  parameter int unsigned W         = LIMB_W,
  parameter int unsigned MAX_LIMBS = adder_pkg::MAX_LIMBS,
  parameter int unsigned IDX_W     = LIMB_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
`ifdef LIMB_CARRY_SIGNED_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_err
);

  chain_state_t     r_state;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_out_valid;
  limb_res_t        r_res;

  logic             w_xfer;
  logic             w_cin;
  logic             w_limit;
  logic             w_last;
  logic [W-1:0]     w_sum;
  logic             w_cout;

  adder #(.W(W)) u_adder (
    .a    (in_a),
    .b    (in_b),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign in_ready = !r_out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;
  assign w_cin    = (r_state == FIRST) ? in_cin : r_carry;
  // Packet hits the limb budget: this limb is forced to be the last one.
  assign w_limit  = (r_idx == IDX_W'(MAX_LIMBS - 1)) && !in_last;
  assign w_last   = in_last || w_limit;

  // Chain state, carry and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FIRST;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_carry     <= w_cout;
      r_res.sum   <= w_sum;
      r_res.idx   <= r_idx;
      r_res.last  <= w_last;
      r_res.cout  <= w_last && w_cout;
      r_res.err   <= w_limit;
      if (w_last) begin
        r_state <= FIRST;
        r_idx   <= '0;
      end else begin
        r_state <= RUN;
        r_idx   <= r_idx + IDX_W'(1);
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef LIMB_CARRY_SIGNED_OVF_EN
  logic r_ovf;
  logic w_msb_cin;

  // Carry into the MSB recovered from the operand and sum MSBs.
  assign w_msb_cin = in_a[W-1] ^ in_b[W-1] ^ w_sum[W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      r_ovf <= w_last && (w_msb_cin ^ w_cout);
    end
  end

  assign out_ovf = r_ovf;
`endif

  assign out_valid = r_out_valid;
  assign out_sum   = r_res.sum;
  assign out_idx   = r_res.idx;
  assign out_last  = r_res.last;
  assign out_cout  = r_res.cout;
  assign out_err   = r_res.err;

endmodule

// File: tb/tb_limb_carry_chain.sv
// tb_limb_carry_chain: directed self-checking bench for limb_carry_chain.
module tb_limb_carry_chain;

  localparam int unsigned W     = 24;
  localparam int unsigned IDX_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_cin;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_cout;
  logic             out_err;
`ifdef LIMB_CARRY_SIGNED_OVF_EN
  logic             out_ovf;
`endif

  int checks;
  int failures;

  limb_carry_chain dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_cout  (out_cout),
`ifdef LIMB_CARRY_SIGNED_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one limb (called at a negedge).
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_last  = last;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if ({out_sum, out_idx, out_last, out_cout, out_err} !== '0) begin failures++;
      $display("FAIL reset_outs got sum=%h idx=%0d last=%0b cout=%0b err=%0b exp all 0", out_sum, out_idx, out_last, out_cout, out_err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single;
    drive(24'hFFFFFF, 24'h000001, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, out_sum, out_idx, out_last, out_cout, out_err} !== {1'b1, 24'h000000, 4'd0, 1'b1, 1'b1, 1'b0}) begin failures++;
      $display("FAIL single got v=%0b sum=%h idx=%0d last=%0b cout=%0b err=%0b exp v=1 sum=000000 idx=0 last=1 cout=1 err=0", out_valid, out_sum, out_idx, out_last, out_cout, out_err); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    drive(24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%0b exp=1", in_ready); end
    @(negedge clk);
    checks++; if ({out_valid, out_sum, out_idx, out_last, out_cout} !== {1'b1, 24'h000000, 4'd0, 1'b0, 1'b0}) begin failures++;
      $display("FAIL b2b_limb0 got v=%0b sum=%h idx=%0d last=%0b cout=%0b exp v=1 sum=000000 idx=0 last=0 cout=0", out_valid, out_sum, out_idx, out_last, out_cout); end
    drive(24'h7FFFFF, 24'h000000, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%0b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, out_sum, out_idx, out_last, out_cout} !== {1'b1, 24'h800000, 4'd1, 1'b1, 1'b0}) begin failures++;
      $display("FAIL b2b_limb1 got v=%0b sum=%h idx=%0d last=%0b cout=%0b exp v=1 sum=800000 idx=1 last=1 cout=0", out_valid, out_sum, out_idx, out_last, out_cout); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(24'hFFFFFF, 24'h000002, 1'b0, 1'b0);  // sum 000001, carry 1
    @(negedge clk);
    drive(24'h000010, 24'h000020, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checks++; if ({in_ready, out_valid, out_sum, out_idx} !== {1'b0, 1'b1, 24'h000001, 4'd0}) begin failures++;
        $display("FAIL bp_hold%0d got rdy=%0b v=%0b sum=%h idx=%0d exp rdy=0 v=1 sum=000001 idx=0", c, in_ready, out_valid, out_sum, out_idx); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, out_sum, out_idx, out_last, out_cout} !== {1'b1, 24'h000031, 4'd1, 1'b1, 1'b0}) begin failures++;
      $display("FAIL bp_limb1 got v=%0b sum=%h idx=%0d last=%0b cout=%0b exp v=1 sum=000031 idx=1 last=1 cout=0", out_valid, out_sum, out_idx, out_last, out_cout); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    drive(24'hFFFFFF, 24'h000001, 1'b0, 1'b0);  // carry_q becomes 1, state RUN
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_async_valid got=%0b exp=0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", out_valid); end
    drive(24'h000001, 24'h000001, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, out_sum, out_idx, out_last, out_cout} !== {1'b1, 24'h000002, 4'd0, 1'b1, 1'b0}) begin failures++;
      $display("FAIL rstmid_fresh got v=%0b sum=%h idx=%0d last=%0b cout=%0b exp v=1 sum=000002 idx=0 last=1 cout=0", out_valid, out_sum, out_idx, out_last, out_cout); end
    @(negedge clk);
  endtask

  // cin=1 on every limb: only the first limb of each packet may use it.
  task automatic test_length_limit;
    logic [W-1:0] exp_sum;
    for (int i = 0; i <= 16; i++) begin
      drive(24'h000000, 24'h000000, 1'b1, (i == 16));
      @(negedge clk);
      exp_sum = (i == 0 || i == 16) ? 24'h000001 : 24'h000000;
      checks++;
      if ({out_valid, out_sum, out_idx, out_last, out_err} !==
          {1'b1, exp_sum, IDX_W'(i % 16), (i >= 15), (i == 15)}) begin
        failures++;
        $display("FAIL len_limb%0d got v=%0b sum=%h idx=%0d last=%0b err=%0b exp v=1 sum=%h idx=%0d last=%0b err=%0b",
                 i, out_valid, out_sum, out_idx, out_last, out_err, exp_sum, i % 16, (i >= 15), (i == 15));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef LIMB_CARRY_SIGNED_OVF_EN
  task automatic test_ovf;
    drive(24'h7FFFFF, 24'h000001, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if ({out_ovf, out_cout, out_sum} !== {1'b1, 1'b0, 24'h800000}) begin failures++;
      $display("FAIL ovf_pos got ovf=%0b cout=%0b sum=%h exp ovf=1 cout=0 sum=800000", out_ovf, out_cout, out_sum); end
    drive(24'hFFFFFF, 24'h000001, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_ovf, out_cout, out_sum} !== {1'b0, 1'b1, 24'h000000}) begin failures++;
      $display("FAIL ovf_neg got ovf=%0b cout=%0b sum=%h exp ovf=0 cout=1 sum=000000", out_ovf, out_cout, out_sum); end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_length_limit();
`ifdef LIMB_CARRY_SIGNED_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/limb_carry_chain.md
Name: limb_carry_chain

Overview:
- Sequential wrapper that adds multi-limb operands, least-significant limb first, one 24-bit limb per beat.
- Sits directly around the 24-bit prefix adder (`adder`):
  - feeds its `cin` with the carry registered from the previous limb;
  - consumes its `sum` and `cout`.
- Presents valid/ready streams on both sides, with a one-stage registered output, so wide sums (48, 72, 96 bits and up) reuse one combinational adder.

Parameters:
- W, 24, limb width; fixed to the adder width, and any other value is illegal.
- MAX_LIMBS, 16, maximum limbs per operand packet.
- IDX_W, 4, width of the limb index; equals clog2(MAX_LIMBS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input limb valid.
- in_ready  out  1  input limb accepted when in_valid&&in_ready.
- in_a  in  W  operand A limb.
- in_b  in  W  operand B limb.
- in_cin  in  1  packet carry-in; sampled only on the first limb of a packet.
- in_last  in  1  marks the most-significant limb of the packet.
- out_valid  out  1  result limb valid.
- out_ready  in  1  downstream accepts the result limb.
- out_sum  out  W  sum limb.
- out_idx  out  IDX_W  limb index within the packet (0 = LS limb).
- out_last  out  1  final limb of the packet.
- out_cout  out  1  packet carry-out; meaningful only when out_last=1, otherwise 0.
- out_err  out  1  length error; set on the forced last limb.

Behaviour:
- Reset, asynchronous and active-high, forces:
  - state = FIRST;
  - carry_q = 0, idx_q = 0;
  - out_valid = 0, out_sum = 0, out_idx = 0, out_last = 0, out_cout = 0, out_err = 0.
- Adder cin:
  - in_cin when state = FIRST;
  - carry_q when state = RUN.
- in_ready = !out_valid || out_ready. This is combinational; there is no skid buffer. Full throughput is one limb per cycle.
- Transfer is the cycle with in_valid && in_ready. On transfer, at the next edge:
  - out_sum <= adder sum;
  - out_idx <= idx_q;
  - out_valid <= 1;
  - carry_q <= adder cout.
  Latency from input transfer to out_valid is 1 cycle.
- If out_valid && out_ready and there is no transfer, out_valid <= 0.
- Output registers hold stable while out_valid && !out_ready.
- State machine:
  - FIRST → RUN on a transfer with in_last=0. idx_q <= 1.
  - FIRST → FIRST on a transfer with in_last=1, which is a single-limb packet. out_last = 1, out_cout = adder cout.
  - RUN → RUN on a transfer with in_last=0 and idx_q < MAX_LIMBS-1. idx_q++.
  - RUN → FIRST on a transfer with in_last=1. out_last = 1, out_cout = adder cout, idx_q <= 0.
- Length limit: a transfer with idx_q == MAX_LIMBS-1 and in_last=0 is treated as last. out_last = 1 and out_err = 1, and the state returns to FIRST.
  - Subsequent limbs start a new packet.
  - out_err is cleared on the next output transfer.
- No transfer means no state or carry change.
- Reset mid-packet discards the partial packet and any pending output. The next accepted limb is treated as a first limb.

Optional Feature:
- Macro LIMB_CARRY_SIGNED_OVF_EN.
- Defined:
  - adds output port out_ovf (1 bit), registered with out_last;
  - out_ovf = carry into the MSB of the top limb XOR out_cout, i.e. two's-complement overflow of the whole packet;
  - out_ovf is 0 on non-last limbs and on reset.
  - Implementation: recompute the MSB carry as a[W-1]^b[W-1]^sum[W-1].
- Undefined: the port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package `adder_pkg`:
  - LIMB_W = 24;
  - enum `chain_state_t` {FIRST, RUN};
  - struct `limb_res_t` {sum, idx, last, cout, err}.
- One sub-module: the existing combinational `adder`, instantiated once. All sequential logic lives in limb_carry_chain.

Test Plan:
- Single limb, a=0xFFFFFF, b=0x000001, cin=0, last=1 → one cycle later: sum=0x000000, idx=0, last=1, cout=1.
- 48-bit add, limbs (0xFFFFFF,0x000001,last=0) then (0x7FFFFF,0x000000,last=1), back-to-back → sums 0x000000 then 0x800000, cout=0; in_ready held high throughout.
- Backpressure: two-limb packet with out_ready=0 for 3 cycles → in_ready=0 and out_sum/out_idx stable. Releasing out_ready → the second limb is accepted the same cycle and appears the next cycle with the correct carry.
- Reset mid-packet: assert rst after limb 0 of a 3-limb packet whose carry_q=1, then send a fresh single limb 0x000001+0x000001, cin=0 → sum 0x000002 (stale carry not used), out_valid=0 right after reset.
- Length limit: 16 limbs of 0x000000+0x000000, all with last=0 → limb 15 shows last=1, err=1. The 17th limb has idx=0 and cin taken from in_cin.
- With LIMB_CARRY_SIGNED_OVF_EN: single limb 0x7FFFFF+0x000001 → ovf=1, cout=0; 0xFFFFFF+0x000001 → ovf=0, cout=1.
